// File: rtl/gbus_burst_arbiter_if.sv
// gbus_burst_arbiter_if: requester handshake and global-bus write signals of the burst arbiter
interface gbus_burst_arbiter_if #(
    parameter int NUM_REQ   = 8,
    parameter int GBUS_DATA = 64,
    parameter int GBUS_ADDR = 12,
    parameter int MAX_BURST = 16,
    parameter int LEN_BIT   = $clog2(MAX_BURST+1)
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*LEN_BIT-1:0]   req_len;
    logic [NUM_REQ*GBUS_ADDR-1:0] req_addr;
    logic [NUM_REQ*GBUS_DATA-1:0] req_wdata;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           gnt;
    logic                         stall;
    logic                         gbus_wen;
    logic [GBUS_ADDR-1:0]         gbus_addr;
    logic [GBUS_DATA-1:0]         gbus_wdata;
    logic                         busy;

    modport master (
        input  req, req_len, req_addr, req_wdata, stall,
        output req_ready, gnt, gbus_wen, gbus_addr, gbus_wdata, busy
    );

    modport slave (
        output req, req_len, req_addr, req_wdata, stall,
        input  req_ready, gnt, gbus_wen, gbus_addr, gbus_wdata, busy
    );
endinterface

// File: rtl/gbus_burst_arbiter.sv
// gbus_burst_arbiter: round-robin burst arbiter sharing one global-bus write port
module gbus_burst_arbiter #(
    parameter int NUM_REQ   = 8,
    parameter int GBUS_DATA = 64,
    parameter int GBUS_ADDR = 12,
    parameter int MAX_BURST = 16,
    parameter int LEN_BIT   = $clog2(MAX_BURST+1)
) (
    input logic clk,
    input logic rst,
    gbus_burst_arbiter_if.master bus
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        owner;
    logic [PW-1:0]        win;
    logic [PW-1:0]        next_ptr;
    logic                 found;
    logic                 accept;
    logic [LEN_BIT-1:0]   rem;
    logic [LEN_BIT-1:0]   win_len;
    logic [LEN_BIT-1:0]   len_clamped;
    logic [GBUS_ADDR-1:0] addr;

    // stall overrides req; only the current owner can be ready
    assign bus.req_ready = bus.gnt & bus.req & {NUM_REQ{~bus.stall}};
    assign accept        = |bus.req_ready;
    assign next_ptr      = (owner == PW'(NUM_REQ-1)) ? '0 : owner + PW'(1);
    assign win_len       = bus.req_len[win*LEN_BIT +: LEN_BIT];
    assign len_clamped   = (win_len == '0) ? LEN_BIT'(1) :
                           (win_len > LEN_BIT'(MAX_BURST)) ? LEN_BIT'(MAX_BURST) : win_len;

    // round-robin scan starting at ptr; descending loop lets the closest requester win
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (bus.req[(int'(ptr)+i) % NUM_REQ]) begin
                found = 1'b1;
                win   = PW'((int'(ptr)+i) % NUM_REQ);
            end
        end
    end

    // arbitration / burst FSM with registered grant and bus write outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            owner          <= '0;
            rem            <= '0;
            addr           <= '0;
            bus.gnt        <= '0;
            bus.busy       <= 1'b0;
            bus.gbus_wen   <= 1'b0;
            bus.gbus_addr  <= '0;
            bus.gbus_wdata <= '0;
        end else begin
            bus.gbus_wen <= 1'b0;
            if (state == IDLE) begin
                if (found) begin
                    state    <= BURST;
                    owner    <= win;
                    rem      <= len_clamped;
                    addr     <= bus.req_addr[win*GBUS_ADDR +: GBUS_ADDR];
                    bus.gnt  <= NUM_REQ'(1) << win;
                    bus.busy <= 1'b1;
                end
            end else if (accept) begin
                bus.gbus_wen   <= 1'b1;
                bus.gbus_addr  <= addr;
                bus.gbus_wdata <= bus.req_wdata[owner*GBUS_DATA +: GBUS_DATA];
                addr           <= addr + GBUS_ADDR'(1);
                rem            <= rem - LEN_BIT'(1);
                if (rem == LEN_BIT'(1)) begin
                    state    <= IDLE;
                    ptr      <= next_ptr;
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/gbus_burst_arbiter.md
# gbus_burst_arbiter

Round-robin burst arbiter that shares one global-bus write port between `NUM_REQ` requesters (per-head loaders, softmax writeback) feeding the core array. A requester wins the bus for a whole burst of up to `MAX_BURST` beats, streams its data through a ready/valid beat handshake, and the arbiter drives registered `gbus_wen`/`gbus_addr`/`gbus_wdata` with auto-incrementing addresses. Downstream backpressure (for example a local-buffer almost-full flag) stalls the burst without dropping beats.

## Interface
- `NUM_REQ`, 8, number of requesters (heads)
- `GBUS_DATA`, 64, global-bus data width
- `GBUS_ADDR`, 12, global-bus address width
- `MAX_BURST`, 16, maximum beats per grant
- `LEN_BIT`, `$clog2(MAX_BURST+1)`, burst-length field width
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `req` in `NUM_REQ`: per-requester request, level
- `req_len` in `NUM_REQ*LEN_BIT`: burst length per requester, sampled at grant
- `req_addr` in `NUM_REQ*GBUS_ADDR`: burst base address, sampled at grant
- `req_wdata` in `NUM_REQ*GBUS_DATA`: beat data per requester
- `req_ready` out `NUM_REQ`: beat accepted this cycle, one-hot or zero
- `gnt` out `NUM_REQ`: current owner, one-hot or zero, registered
- `stall` in 1: downstream backpressure
- `gbus_wen` out 1: bus write strobe, registered
- `gbus_addr` out `GBUS_ADDR`: bus write address, registered
- `gbus_wdata` out `GBUS_DATA`: bus write data, registered
- `busy` out 1: high in BURST state

## Operation
- Two states: IDLE and BURST.
- **Arbitration in IDLE.**
  - Scan `req` starting at `ptr` and wrapping round; the first requester with `req` set wins.
  - The winner's `req_len` and `req_addr` are latched.
  - `gnt` is set to the winner, `busy` goes to 1, and the state moves to BURST.
  - A latched length of 0 is treated as 1. Lengths above `MAX_BURST` are clamped to `MAX_BURST`.
- **Beat handshake in BURST.**
  - `req_ready[w] = gnt[w] & req[w] & !stall`. This is combinational, and the requester presents its next beat the cycle after a ready.
  - On each accepted beat, the next cycle drives `gbus_wen=1`, `gbus_wdata` = the accepted data, and `gbus_addr` = base + beat index.
  - The address wraps modulo 2^`GBUS_ADDR`.
  - The remaining-beat counter decrements on each accept.
- **Holds during a burst.**
  - If `req[w]` drops, no beat is accepted and the burst holds. The requester cannot abort; it must re-assert `req`.
  - If `stall` is high, no beat is accepted, `gbus_wen` is 0 on the next cycle, and the counter and address hold.
- **Burst end.**
  - On acceptance of the last beat, the next cycle has `gnt=0` and `busy=0`, the state returns to IDLE, and `ptr` becomes winner+1 (mod `NUM_REQ`).
  - The final `gbus_wen` is still issued in that cycle.
- **Fairness.** The winner of a burst has the lowest priority in the next arbitration. Every continuously requesting requester is granted within `NUM_REQ` bursts.
- **Outputs between writes.** `gbus_addr` and `gbus_wdata` hold their last values when `gbus_wen=0`.

## Timing
- **Reset values** (`rst` asserted, asynchronous):
  - State = IDLE, `ptr` = 0.
  - `gnt` = 0, `busy` = 0, `gbus_wen` = 0, `gbus_addr` = 0, `gbus_wdata` = 0.
  - `req_ready` = 0, because `gnt` is 0.
- **Grant latency.**
  - `req` sampled in IDLE at cycle N gives `gnt`/`busy` at N+1.
  - The first `req_ready` is possible at N+1.
  - The first `gbus_wen` is at N+2.
- **Throughput.** One beat per cycle when unstalled. An L-beat burst occupies L BURST cycles plus one IDLE arbitration cycle.
- **Next arbitration.** The IDLE cycle after a burst arbitrates using `req` values present in that cycle.
- **Reset mid-burst.** All outputs go to reset values immediately. Remaining beats are discarded, and no `gbus_wen` is issued after `rst` rises. After `rst` falls, arbitration restarts from `ptr=0`.
- **Same-cycle `stall` and `req`.** `stall` has priority: `req_ready` is 0 regardless of `req`.
- **Arbitration ignores `stall`.** The grant can be issued while `stall` is high.

## Test plan
- **Single burst.** Reset, then `req[2]=1`, `len=4`, `addr=0x100`, no stall.
  - `gnt=0b100` one cycle later.
  - 4 consecutive `req_ready[2]` pulses.
  - `gbus_wen` on 4 cycles with `addr` 0x100–0x103 and matching data.
  - `busy` falls after the last ready.
- **Round-robin fairness.** `req` = all ones with `len=1` on every requester.
  - Grant order 0,1,2,…,7,0.
  - Each grant lasts 2 cycles (BURST + IDLE).
- **Backpressure.** `len=8`, `stall` high for the cycles carrying beats 3 and 4.
  - Exactly 8 `gbus_wen` pulses.
  - Addresses contiguous, with no duplicates or gaps.
  - `gbus_wen` low on the cycles after the stalled cycles.
- **Wrap and clamp.** `addr=0xFFE`, `len=4` gives addresses 0xFFE, 0xFFF, 0x000, 0x001. `len=0` gives 1 beat.
- **Requester drop mid-burst.** `len=4` with `req` deasserted for 3 cycles after beat 2.
  - The burst holds and `gnt` is retained.
  - Remaining beats complete after `req` returns.
- **Reset mid-burst.** Assert `rst` during beat 3 of 6.
  - `gbus_wen`, `gnt` and `busy` are 0 at once.
  - After release, `req[5]` alone is granted normally, with `ptr` restarted at 0.
